display_timing_gen: RTL and testbench

Raster timing generator for the 1280x1024@60 display path. Counts pixel clocks into horizontal and vertical positions and produces the `x`, `y`, `valid` and `vsync` inputs consumed by `wave_display_top`. It also produces delayed sync and data-enable outputs, aligned to the RGB pipeline latency, that drive the video encoder.

---
 rtl/display_pkg.sv | 42 ++++
 rtl/sig_delay.sv | 46 ++++
 rtl/display_timing_gen.sv | 162 ++++++++++++++++
 tb/tb_display_timing_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
//   Shared constants and types for the 1280x1024@60 raster path.
//   - Per-axis timing (ACTIVE / FP / SYNC / BP) and the resulting totals.
//   - Position widths X_W / Y_W and the raster counter width CNT_W.
//   - sync_bus_t: the {hsync, vsync, de} bundle carried by the delay line.
//   - in_window(): half-open interval test used by the region decode.
package display_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int H_FP     = 48;
    localparam int H_SYNC   = 112;
    localparam int H_BP     = 248;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1688

    localparam int V_ACTIVE = 1024;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 38;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 1066

    localparam int X_W         = 11;
    localparam int Y_W         = 10;
    // Both counters share one width; 1687 and 1065 both fit in 11 bits.
    localparam int CNT_W       = 11;
    localparam int FRAME_CNT_W = 16;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    // True when lo <= v < hi, compared at full counter width.
    function automatic logic in_window(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/sig_delay.sv
// sig_delay
//   Parameterised shift register used to align control signals with a
//   fixed-latency data pipeline. Output q equals input d exactly DEPTH
//   clocks earlier; every stage clears asynchronously on reset.
//   Ports:
//     clk    in   1      clock
//     reset  in   1      asynchronous, active-high
//     d      in   WIDTH  input word
//     q      out  WIDTH  d delayed by DEPTH clocks
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= d;
                    end
                end
            end else begin : g_follow
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_stage[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    assign q = g_stage[DEPTH-1].stage_reg;

endmodule

// File: rtl/display_timing_gen.sv
// display_timing_gen
//   Raster timing generator for the 1280x1024@60 display path. Two 11-bit
//   counters walk the raster; registered decodes of them drive the position
//   and sync outputs, and a PIPE_DELAY-deep delay line produces copies of
//   the syncs and data-enable aligned with the RGB pipeline.
//   Optional feature: define DISPLAY_TIMING_FRAME_CNT_EN to add a 16-bit
//   wrapping frame counter output (frame_count).
//   Ports:
//     clk          in   1   pixel clock (108 MHz)
//     reset        in   1   asynchronous, active-high
//     x            out  11  horizontal position, 0 outside the active region
//     y            out  10  vertical position, 0 outside the active region
//     valid        out  1   (x, y) is a visible pixel
//     vsync        out  1   vertical sync, positive, undelayed
//     hsync        out  1   horizontal sync, positive, undelayed
//     frame_start  out  1   one-clock pulse at h=0, v=0
//     hsync_d      out  1   hsync delayed by PIPE_DELAY
//     vsync_d      out  1   vsync delayed by PIPE_DELAY
//     de_d         out  1   valid delayed by PIPE_DELAY
//     frame_count  out  16  frames started since reset (optional)
//   The timing parameters default to the package's 1280x1024 values.
//   PIPE_DELAY legal range is 1..7.
module display_timing_gen #(
    parameter int H_ACTIVE   = display_pkg::H_ACTIVE,
    parameter int H_FP       = display_pkg::H_FP,
    parameter int H_SYNC     = display_pkg::H_SYNC,
    parameter int H_BP       = display_pkg::H_BP,
    parameter int V_ACTIVE   = display_pkg::V_ACTIVE,
    parameter int V_FP       = display_pkg::V_FP,
    parameter int V_SYNC     = display_pkg::V_SYNC,
    parameter int V_BP       = display_pkg::V_BP,
    parameter int PIPE_DELAY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [display_pkg::X_W-1:0] x,
    output logic [display_pkg::Y_W-1:0] y,
    output logic                      valid,
    output logic                      vsync,
    output logic                      hsync,
    output logic                      frame_start,
    output logic                      hsync_d,
    output logic                      vsync_d,
    output logic                      de_d
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    ,
    output logic [display_pkg::FRAME_CNT_W-1:0] frame_count
`endif
);

    import display_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt_reg;
    logic [CNT_W-1:0] vcnt_reg;

    logic [X_W-1:0] x_reg,  x_next;
    logic [Y_W-1:0] y_reg,  y_next;
    logic           valid_reg, valid_next;
    logic           hsync_reg, hsync_next;
    logic           vsync_reg, vsync_next;
    logic           frame_start_reg, frame_start_next;

    // Raster counters: hcnt wraps every line, vcnt steps on each hcnt wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (hcnt_reg == H_LAST) begin
            hcnt_reg <= '0;
            vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + CNT_W'(1);
        end else begin
            hcnt_reg <= hcnt_reg + CNT_W'(1);
        end
    end

    // Region decode of the current count. The registers below capture it on
    // the same edge that advances the counters, so outputs lag by one stage.
    always_comb begin
        valid_next       = (hcnt_reg < H_ACT_END) && (vcnt_reg < V_ACT_END);
        hsync_next       = in_window(hcnt_reg, HS_START, HS_END);
        vsync_next       = in_window(vcnt_reg, VS_START, VS_END);
        frame_start_next = (hcnt_reg == '0) && (vcnt_reg == '0);
        x_next           = '0;
        y_next           = '0;
        if (valid_next) begin
            // vcnt was range-checked at full width above, so truncation is safe.
            x_next = hcnt_reg[X_W-1:0];
            y_next = vcnt_reg[Y_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg           <= '0;
            y_reg           <= '0;
            valid_reg       <= 1'b0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            valid_reg       <= valid_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign x           = x_reg;
    assign y           = y_reg;
    assign valid       = valid_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign frame_start = frame_start_reg;

    // The delay line taps the registered outputs, so *_d trails the
    // undelayed outputs by exactly PIPE_DELAY clocks.
    sync_bus_t sync_in;
    sync_bus_t sync_out;

    assign sync_in = '{hsync: hsync_reg, vsync: vsync_reg, de: valid_reg};

    sig_delay #(
        .WIDTH ($bits(sync_bus_t)),
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .d     (sync_in),
        .q     (sync_out)
    );

    assign hsync_d = sync_out.hsync;
    assign vsync_d = sync_out.vsync;
    assign de_d    = sync_out.de;

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_count_reg;

    // Counts on the edge that raises frame_start; wraps naturally at 2^16.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_reg <= '0;
        end else if (frame_start_next) begin
            frame_count_reg <= frame_count_reg + FRAME_CNT_W'(1);
        end
    end

    assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
module tb_display_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        valid;
        logic        hsync;
        logic        vsync;
        logic        fs;
        logic        hsd;
        logic        vsd;
        logic        ded;
    } obs_t;

    typedef struct {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int pd;
    } tim_t;

    typedef struct {
        int n;
        int x;
        int y;
        bit valid;
        bit hsync;
        bit vsync;
        bit fs;
        bit ded;
    } vec_t;

    localparam int LAST_N = 4077;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset_s;

    logic [10:0] x,  x_s;
    logic [9:0]  y,  y_s;
    logic valid, vsync, hsync, frame_start, hsync_d, vsync_d, de_d;
    logic valid_s, vsync_s, hsync_s, frame_start_s, hsync_d_s, vsync_d_s, de_d_s;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count, frame_count_s;
`endif

    display_timing_gen u_dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .valid       (valid),
        .vsync       (vsync),
        .hsync       (hsync),
        .frame_start (frame_start),
        .hsync_d     (hsync_d),
        .vsync_d     (vsync_d),
        .de_d        (de_d)
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    // Shrunken raster (16 x 8 clocks, 128-clock frame) so whole frames fit.
    display_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .PIPE_DELAY (3)
    ) u_small (
        .clk         (clk),
        .reset       (reset_s),
        .x           (x_s),
        .y           (y_s),
        .valid       (valid_s),
        .vsync       (vsync_s),
        .hsync       (hsync_s),
        .frame_start (frame_start_s),
        .hsync_d     (hsync_d_s),
        .vsync_d     (vsync_d_s),
        .de_d        (de_d_s)
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
        ,
        .frame_count (frame_count_s)
`endif
    );

    obs_t act_def, act_small;
    assign act_def   = {x, y, valid, hsync, vsync, frame_start, hsync_d, vsync_d, de_d};
    assign act_small = {x_s, y_s, valid_s, hsync_s, vsync_s, frame_start_s, hsync_d_s, vsync_d_s, de_d_s};

    int checks   = 0;
    int failures = 0;

    obs_t exp_q[$];
    obs_t exp_s_q[$];
    obs_t hist   [LAST_N+1];
    obs_t hist_s [LAST_N+1];
    vec_t tbl    [12];
    tim_t t_def, t_small;

    // Undelayed outputs after the n-th edge since reset release (n >= 1);
    // that edge registers the decode of raster count n-1.
    function automatic obs_t base(int n, tim_t t);
        obs_t o;
        int c, h, v, htot, vtot;
        o = '0;
        if (n < 1) return o;
        htot = t.ha + t.hfp + t.hs + t.hbp;
        vtot = t.va + t.vfp + t.vs + t.vbp;
        c = n - 1;
        h = c % htot;
        v = (c / htot) % vtot;
        o.valid = (h < t.ha) && (v < t.va);
        o.hsync = (h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hs);
        o.vsync = (v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vs);
        o.fs    = (h == 0) && (v == 0);
        if (o.valid) begin
            o.x = 11'(h);
            o.y = 10'(v);
        end
        return o;
    endfunction

    function automatic obs_t model(int n, tim_t t);
        obs_t o, d;
        o = base(n, t);
        d = base(n - t.pd, t);
        o.hsd = d.hsync;
        o.vsd = d.vsync;
        o.ded = d.valid;
        return o;
    endfunction

    task automatic check_obs(input string name, input int n, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s n=%0d actual x=%0d y=%0d v=%b hs=%b vs=%b fs=%b hsd=%b vsd=%b ded=%b required x=%0d y=%0d v=%b hs=%b vs=%b fs=%b hsd=%b vsd=%b ded=%b",
                         name, n, a.x, a.y, a.valid, a.hsync, a.vsync, a.fs, a.hsd, a.vsd, a.ded,
                         e.x, e.y, e.valid, e.hsync, e.vsync, e.fs, e.hsd, e.vsd, e.ded);
        end else begin
            $display("ok   %s n=%0d x=%0d y=%0d v=%b hs=%b vs=%b fs=%b", name, n, a.x, a.y, a.valid, a.hsync, a.vsync, a.fs);
        end
    endtask

    task automatic check_val(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, a, e);
        end else begin
            $display("ok   %s value=%0d", name, a);
        end
    endtask

    initial begin
        obs_t e;
        int cnt_valid, cnt_hs, first_hs, first_nv, cnt_fs, cnt_vs, first_vs, max_y;

        t_def   = '{ha: 1280, hfp: 48, hs: 112, hbp: 248, va: 1024, vfp: 1, vs: 3, vbp: 38, pd: 2};
        t_small = '{ha: 8,    hfp: 2,  hs: 3,   hbp: 3,   va: 4,    vfp: 1, vs: 2, vbp: 1,  pd: 3};

        //            n     x     y  valid hs vs fs ded
        tbl[0]  = '{1,    0,    0, 1, 0, 0, 1, 0};
        tbl[1]  = '{2,    1,    0, 1, 0, 0, 0, 0};
        tbl[2]  = '{3,    2,    0, 1, 0, 0, 0, 1};
        tbl[3]  = '{1280, 1279, 0, 1, 0, 0, 0, 1};
        tbl[4]  = '{1281, 0,    0, 0, 0, 0, 0, 1};
        tbl[5]  = '{1328, 0,    0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1329, 0,    0, 0, 1, 0, 0, 0};
        tbl[7]  = '{1440, 0,    0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1441, 0,    0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1689, 0,    1, 1, 0, 0, 0, 0};
        tbl[10] = '{1789, 100,  1, 1, 0, 0, 0, 1};
        tbl[11] = '{3377, 0,    2, 1, 0, 0, 0, 0};

        reset   = 1'b1;
        reset_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset_def", 0, act_def, '0);
        check_obs("reset_small", 0, act_small, '0);
        @(negedge clk);
        reset   = 1'b0;
        reset_s = 1'b0;

        // Scoreboard run: each clock edge is the stimulus; the expectation is
        // queued before the edge and compared once the registered outputs update.
        for (int n = 1; n <= LAST_N; n++) begin
            exp_q.push_back(model(n, t_def));
            exp_s_q.push_back(model(n, t_small));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check_obs("sb_def", n, act_def, e);
            hist[n] = act_def;
            e = exp_s_q.pop_front();
            check_obs("sb_small", n, act_small, e);
            hist_s[n] = act_small;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
            if (n == 1)    check_val("fcnt_first", int'(frame_count), 1);
            if (n == 3584) check_val("fcnt_28_frames", int'(frame_count_s), 28);
            if (n == 3585) begin
                check_val("fcnt_29", int'(frame_count_s), 29);
                u_small.frame_count_reg = 16'hFFFF;
            end
            if (n == 3712) check_val("fcnt_max", int'(frame_count_s), 65535);
            if (n == 3713) check_val("fcnt_wrap", int'(frame_count_s), 0);
`endif
        end

        for (int k = 0; k < 12; k++) begin
            e = '0;
            e.x     = 11'(tbl[k].x);
            e.y     = 10'(tbl[k].y);
            e.valid = tbl[k].valid;
            e.hsync = tbl[k].hsync;
            e.vsync = tbl[k].vsync;
            e.fs    = tbl[k].fs;
            e.ded   = tbl[k].ded;
            check_obs("tbl", tbl[k].n,
                      {hist[tbl[k].n].x, hist[tbl[k].n].y, hist[tbl[k].n].valid, hist[tbl[k].n].hsync,
                       hist[tbl[k].n].vsync, hist[tbl[k].n].fs, 1'b0, 1'b0, hist[tbl[k].n].ded}, e);
        end

        // Line-level shape of the full-size raster (first line).
        cnt_valid = 0; cnt_hs = 0; first_hs = -1; first_nv = -1;
        for (int n = 1; n <= 1688; n++) begin
            if (hist[n].valid) cnt_valid++;
            else if (first_nv < 0) first_nv = n;
            if (hist[n].hsync) begin
                cnt_hs++;
                if (first_hs < 0) first_hs = n;
            end
        end
        check_val("line_valid_clocks", cnt_valid, 1280);
        check_val("line_hsync_clocks", cnt_hs, 112);
        check_val("hsync_gap_after_valid", first_hs - first_nv, 48);

        // Frame-level shape of the small raster.
        cnt_fs = 0; cnt_vs = 0; first_vs = -1; max_y = 0;
        for (int n = 1; n <= 3584; n++) begin
            if (hist_s[n].fs) cnt_fs++;
            if (hist_s[n].valid && int'(hist_s[n].y) > max_y) max_y = int'(hist_s[n].y);
            if (n <= 128 && hist_s[n].vsync) begin
                cnt_vs++;
                if (first_vs < 0) first_vs = n;
            end
        end
        check_val("small_frame_starts", cnt_fs, 28);
        check_val("small_vsync_clocks", cnt_vs, 32);
        check_val("small_vsync_first", first_vs, 81);
        check_val("small_max_y", max_y, 3);

        // Reset in the middle of a line of the full-size raster.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_obs("midreset_async", 0, act_def, '0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check_obs("midreset_hold", k, act_def, '0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            exp_q.push_back(model(n, t_def));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check_obs("after_reset", n, act_def, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
